// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: control-bundle field layout, default width and bubble constant
package ctrl_pipe_pkg;
  localparam int CTRL_W_DEF = 13;
  localparam int RF_EN = 0;
  localparam int MEM_EN = 1;
  localparam int MEM_RW = 2;
  localparam int MEM_SIZE = 3;
  localparam int LOAD = 4;
  localparam int ALU_OP_LO = 5;
  localparam int ALU_OP_HI = 8;
  localparam int S_BIT = 9;
  localparam int B_BL = 10;
  localparam int AM_LO = 11;
  localparam int AM_HI = 12;
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;
endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one control register stage with flush > hold > bubble > load priority
module ctrl_pipe_stage import ctrl_pipe_pkg::*; #(
  parameter int W = CTRL_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         flush,
  input  logic         load_bubble,
  input  logic [W-1:0] d,
  input  logic         valid_d,
  output logic [W-1:0] q,
  output logic         valid_q
);
  always_ff @(posedge clk)
    if (reset || flush) begin
      q <= '0;
      valid_q <= 1'b0;
    end else if (!hold) begin
      q <= load_bubble ? '0 : d;
      valid_q <= valid_d & ~load_bubble;
    end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: parametrised control pipeline with stall/flush/bubbles; CTRL_PIPE_PERF_EN adds counters
module ctrl_pipe import ctrl_pipe_pkg::*; #(
  parameter int STAGES = 3,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic                     in_valid,
  input  logic                     hazard_bubble,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  output logic [STAGES*CTRL_W-1:0] ctrl_out,
  output logic [STAGES-1:0]        valid_out,
  output logic [CTRL_W-1:0]        id_ctrl,
  output logic                     id_stall,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);
  logic [STAGES-1:0] hold;
  logic id_valid;
  // a stall anywhere downstream freezes every stage upstream of it
  always_comb begin
    hold = '0;
    for (int k = 0; k < STAGES; k++) hold[k] = |(stall >> k);
  end
  assign id_valid = in_valid & ~hazard_bubble;
  assign id_ctrl = id_valid ? ctrl_in : '0;
  assign id_stall = hold[0];
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      ctrl_pipe_stage #(.W(CTRL_W)) u_stage (
        .clk(clk), .reset(reset), .hold(hold[0]), .flush(flush[0]), .load_bubble(1'b0),
        .d(id_ctrl), .valid_d(id_valid),
        .q(ctrl_out[0 +: CTRL_W]), .valid_q(valid_out[0])
      );
    end else begin : g_next
      ctrl_pipe_stage #(.W(CTRL_W)) u_stage (
        .clk(clk), .reset(reset), .hold(hold[s]), .flush(flush[s]), .load_bubble(hold[s-1]),
        .d(ctrl_out[(s-1)*CTRL_W +: CTRL_W]), .valid_d(valid_out[s-1]),
        .q(ctrl_out[s*CTRL_W +: CTRL_W]), .valid_q(valid_out[s])
      );
    end
  end
`ifdef CTRL_PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  always_ff @(posedge clk)
    if (reset) begin
      bubble_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (!hold[0] && !id_valid && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
      if (hold[0] && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
    end
`else
  assign bubble_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-signal pipeline that carries the decoded control bundle from the ID stage through the downstream pipeline stages (EX, MEM, WB by default). It generalises the fixed ID/EX, EX/MEM and MEM/WB control registers and the hazard multiplexer into one block. It adds a configurable stage count and bundle width, per-stage valid tracking, per-stage stall and flush, and automatic bubble insertion. It sits between the control unit output and the datapath stage consumers.

## Interface
- STAGES, 3: number of register stages after ID; stage 0 is EX. Minimum 1.
- CTRL_W, 13: width of one control bundle. Field layout is defined in the package.
- CNT_W, 32: width of the performance counters.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; clears all state
- ctrl_in  in  CTRL_W  control bundle from the control unit (ID stage)
- in_valid  in  1  ctrl_in holds a real instruction
- hazard_bubble  in  1  replaces the ID bundle with a bubble (all-zero, invalid)
- stall  in  STAGES  stall[i]=1 requests that stage i hold its contents
- flush  in  STAGES  flush[i]=1 loads a bubble into stage i at the next edge
- ctrl_out  out  STAGES*CTRL_W  stage i bundle at [i*CTRL_W +: CTRL_W]
- valid_out  out  STAGES  stage i holds a real instruction
- id_ctrl  out  CTRL_W  muxed ID bundle: the bundle presented to stage 0 (combinational)
- id_stall  out  1  ID/IF must hold; equals hold[0]
- bubble_cnt  out  CNT_W  performance counter (see Configuration)
- stall_cnt  out  CNT_W  performance counter (see Configuration)

## Operation
- Bubble: ctrl = 0, valid = 0.
- Hold propagation: hold[i] = OR of stall[j] for all j >= i. A stall at a stage freezes every upstream stage.
- ID mux:
  - id_ctrl = ctrl_in when in_valid=1 and hazard_bubble=0; otherwise 0.
  - The ID valid bit follows the same rule.
- Per stage i, at each clock edge, in priority order:
  - reset: load a bubble.
  - flush[i]: load a bubble. Flush overrides hold.
  - hold[i]: keep the current contents.
  - i>0 and hold[i-1]=1: load a bubble. The upstream stage is frozen, so a gap opens behind the stalled point.
  - otherwise: load from the upstream stage. Stage 0 loads the ID mux output; stage i>0 loads stage i-1.
- Outputs are registered, except id_ctrl and id_stall.
- A flush of a held stage discards that stage's instruction. Upstream stages still hold.

## Timing
- Reset values: ctrl_out=0, valid_out=0, bubble_cnt=0, stall_cnt=0.
- Latency: with no stalls or flushes, a bundle accepted at ID on edge n appears at stage i after edge n+i+1. The default WB stage (i=2) therefore sees it 3 cycles after ID.
- Stall of stage k for m cycles:
  - Stages 0..k freeze for m cycles.
  - Stage k+1 receives m bubbles.
  - No bundle is lost or duplicated.
- The last stage (STAGES-1) has no downstream consumer. Its contents are overwritten each unheld cycle.
- Reset asserted mid-stall or mid-flush: all stages are bubbles after that edge. Normal flow resumes on the first edge with reset=0.
- STAGES=1: stage 0 only; the "upstream held" rule does not apply.

## Configuration
- Macro: CTRL_PIPE_PERF_EN.
- Defined:
  - bubble_cnt increments on every edge where stage 0 loads a bubble through the ID mux (hazard_bubble=1 or in_valid=0) while hold[0]=0.
  - stall_cnt increments on every edge where hold[0]=1.
  - Both counters saturate at 2^CNT_W-1 and clear on reset.
- Undefined:
  - No counter flops are built.
  - bubble_cnt and stall_cnt are tied to 0.
  - The port list is unchanged.

## Structure
- Package ctrl_pipe_pkg holds:
  - CTRL_W default.
  - Field offset constants: RF_EN=0, MEM_EN=1, MEM_RW=2, MEM_SIZE=3, LOAD=4, ALU_OP=8:5, S_BIT=9, B_BL=10, AM=12:11.
  - The CTRL_BUBBLE constant (all zero).
- Sub-module ctrl_pipe_stage implements one register stage: clk, reset, hold, flush, load_bubble, d/valid_d in, q/valid_q out.
- ctrl_pipe instantiates STAGES copies of ctrl_pipe_stage in a generate loop, plus the ID mux, hold-propagation logic and the optional counters.

## Test plan
- Reset and flow: hold reset for 3 cycles → all outputs 0. Release reset, then drive ctrl_in=13'h0A1, in_valid=1 for one cycle → stage 0/1/2 show 13'h0A1 with valid=1 on successive edges; all other cycles show bubbles.
- Hazard bubble: stream 13'h001, 13'h002, 13'h003 with hazard_bubble=1 during 13'h002 → stage 0 sequence 001, 000 (valid 0), 003. bubble_cnt=1 when CTRL_PIPE_PERF_EN is defined, 0 otherwise.
- Stall: stall[1]=1 for 2 cycles while the stream 1..5 flows → stages 0 and 1 frozen for 2 cycles, stage 2 receives two bubbles, id_stall=1 for 2 cycles, stall_cnt=2, final WB order is 1,2,3,4,5 with no loss.
- Flush over stall: stall[0]=1 and flush[0]=1 in the same cycle with stage 0=13'h004 → stage 0 becomes a bubble, id_stall=1, and the ID bundle is retained for the next cycle.
- Reset mid-operation: assert reset with all stages valid and stall[2]=1 → every valid_out=0 and every ctrl_out=0 after one edge, counters=0.
- Parameter sweep: STAGES=1 and STAGES=5 with CTRL_W=8 → a single bundle 8'h5A appears at stage i exactly i+1 edges after ID acceptance, and the counters saturate correctly with CNT_W=2 (value stays at 3).
